// File: rtl/cache_mem_pkg.sv
// Shared cache/memory definitions: refill FSM state encoding and default geometry.
// The FWD state exists only when WB_FORWARD_EN is defined.
package cache_mem_pkg;

    localparam int DEF_BLOCK_SIZE = 32'd256;
    localparam int DEF_ADDR_WIDTH = 32'd16;

`ifdef WB_FORWARD_EN
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_RESP     = 3'd3,
        ST_FWD      = 3'd4
    } rd_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_RESP     = 3'd3
    } rd_state_e;
`endif

endpackage

// File: rtl/mem_refill_initiator_wb_fifo.sv
// Writeback FIFO (module wb_fifo) with an age-ordered address-match vector.
// The peek port for forwarding exists only when WB_FORWARD_EN is defined.
module wb_fifo
    import cache_mem_pkg::*;
#(
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = 32'd4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [ADDR_WIDTH-1:0]      push_addr,
    input  logic [BLOCK_SIZE-1:0]      push_block,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [ADDR_WIDTH-1:0]      head_addr,
    output logic [BLOCK_SIZE-1:0]      head_block,
    input  logic [ADDR_WIDTH-1:0]      match_addr,
`ifdef WB_FORWARD_EN
    input  logic [$clog2(DEPTH)-1:0]   peek_age,
    output logic [BLOCK_SIZE-1:0]      peek_block,
`endif
    output logic [DEPTH-1:0]           match_vec
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 32'd1;

    logic [ADDR_WIDTH-1:0] addr_mem_r  [DEPTH];
    logic [BLOCK_SIZE-1:0] block_mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;

    // Entry storage, written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_r[wr_ptr_r]  <= push_addr;
            block_mem_r[wr_ptr_r] <= push_block;
        end
    end

    // Pointers wrap at DEPTH; count disambiguates full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign full       = (count_r == CNT_W'(DEPTH));
    assign empty      = (count_r == {CNT_W{1'b0}});
    assign head_addr  = addr_mem_r[rd_ptr_r];
    assign head_block = block_mem_r[rd_ptr_r];

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0] peek_idx_s;
    assign peek_idx_s = rd_ptr_r + peek_age;
    assign peek_block = block_mem_r[peek_idx_s];
`endif

    // Bit k covers the entry of age k (0 = oldest); only occupied slots can hit.
    always_comb begin
        match_vec = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            logic [PTR_W-1:0] idx_s;
            idx_s        = rd_ptr_r + PTR_W'(k);
            match_vec[k] = (CNT_W'(k) < count_r) && (addr_mem_r[idx_s] == match_addr);
        end
    end

endmodule

// File: rtl/mem_refill_initiator.sv
// Cache refill initiator: read FSM with settle window plus a writeback drain FIFO.
// WB_FORWARD_EN: forward hazarding requests from the FIFO instead of stalling them.
module mem_refill_initiator
    import cache_mem_pkg::*;
#(
    parameter int BLOCK_SIZE    = DEF_BLOCK_SIZE,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int WB_DEPTH      = 32'd4,
    parameter int SETTLE_CYCLES = 32'd2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [BLOCK_SIZE-1:0] resp_block,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [BLOCK_SIZE-1:0] wb_block,
    output logic                  wb_ready,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    input  logic                  mem_block_ready,
    input  logic [BLOCK_SIZE-1:0] mem_q,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [BLOCK_SIZE-1:0] mem_block,
    input  logic                  mem_fifo_full
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 32'd2);

    rd_state_e             state_r;
    logic [SET_W-1:0]      settle_cnt_r;
    logic                  resp_valid_r;
    logic [BLOCK_SIZE-1:0] resp_block_r;
    logic [ADDR_WIDTH-1:0] mem_r_addr_r;

    logic                  wb_full_s;
    logic                  wb_empty_s;
    logic                  wb_push_s;
    logic                  wb_pop_s;
    logic [WB_DEPTH-1:0]   match_vec_s;
    logic                  push_hit_s;
    logic                  hazard_s;
    logic                  accept_s;

`ifdef WB_FORWARD_EN
    localparam int PTR_W = $clog2(WB_DEPTH);
    logic [PTR_W-1:0]      fwd_age_s;
    logic [BLOCK_SIZE-1:0] peek_block_s;
    logic [BLOCK_SIZE-1:0] fwd_block_s;
`endif

    // No pop credit: a full FIFO refuses pushes even in a cycle it drains.
    assign wb_ready   = !wb_full_s;
    assign wb_push_s  = wb_valid && !wb_full_s;
    assign mem_we     = !rst && !wb_empty_s && !mem_fifo_full;
    assign wb_pop_s   = mem_we;

    assign push_hit_s = wb_push_s && (wb_addr == req_addr);
    assign hazard_s   = push_hit_s || (|match_vec_s);

`ifdef WB_FORWARD_EN
    assign req_ready  = !rst && (state_r == ST_IDLE);
`else
    assign req_ready  = !rst && (state_r == ST_IDLE) && !hazard_s;
`endif
    assign accept_s   = req_valid && req_ready;

    wb_fifo #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (WB_DEPTH)
    ) u_wb_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (wb_push_s),
        .push_addr  (wb_addr),
        .push_block (wb_block),
        .pop        (wb_pop_s),
        .full       (wb_full_s),
        .empty      (wb_empty_s),
        .head_addr  (mem_w_addr),
        .head_block (mem_block),
        .match_addr (req_addr),
`ifdef WB_FORWARD_EN
        .peek_age   (fwd_age_s),
        .peek_block (peek_block_s),
`endif
        .match_vec  (match_vec_s)
    );

`ifdef WB_FORWARD_EN
    // Youngest match wins; a same-cycle push is younger than anything queued.
    always_comb begin
        fwd_age_s = {PTR_W{1'b0}};
        for (int k = 0; k < WB_DEPTH; k++) begin
            fwd_age_s = match_vec_s[k] ? PTR_W'(k) : fwd_age_s;
        end
        fwd_block_s = push_hit_s ? wb_block : peek_block_s;
    end
`endif

    // Read FSM: accept, ignore memory during settle, capture, pulse response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= {SET_W{1'b0}};
            resp_valid_r <= 1'b0;
            resp_block_r <= {BLOCK_SIZE{1'b0}};
            mem_r_addr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            resp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
`ifdef WB_FORWARD_EN
                        if (hazard_s) begin
                            resp_block_r <= fwd_block_s;
                            resp_valid_r <= 1'b1;
                            state_r      <= ST_FWD;
                        end else begin
                            mem_r_addr_r <= req_addr;
                            settle_cnt_r <= SET_W'(SETTLE_CYCLES);
                            state_r      <= ST_SETTLE;
                        end
`else
                        mem_r_addr_r <= req_addr;
                        settle_cnt_r <= SET_W'(SETTLE_CYCLES);
                        state_r      <= ST_SETTLE;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt_r <= settle_cnt_r - SET_W'(1);
                    if (settle_cnt_r <= SET_W'(1)) begin
                        state_r <= ST_WAIT_RDY;
                    end else begin
                        state_r <= ST_SETTLE;
                    end
                end
                ST_WAIT_RDY: begin
                    if (mem_block_ready) begin
                        resp_block_r <= mem_q;
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_RESP;
                    end else begin
                        state_r <= ST_WAIT_RDY;
                    end
                end
                ST_RESP: state_r <= ST_IDLE;
`ifdef WB_FORWARD_EN
                ST_FWD:  state_r <= ST_IDLE;
`endif
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_block = resp_block_r;
    assign mem_r_addr = mem_r_addr_r;

endmodule

// File: tb/tb_mem_refill_initiator.sv
// Scoreboard bench for mem_refill_initiator: directed scenarios plus randomized traffic.
module tb_mem_refill_initiator;

    localparam int BS = 256;
    localparam int AW = 16;
    localparam int WD = 4;
    localparam int SC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          req_ready;
    logic          resp_valid;
    logic [BS-1:0] resp_block;
    logic          wb_valid = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [BS-1:0] wb_block = '0;
    logic          wb_ready;
    logic [AW-1:0] mem_r_addr;
    logic          mem_block_ready = 1'b0;
    logic [BS-1:0] mem_q = '0;
    logic          mem_we;
    logic [AW-1:0] mem_w_addr;
    logic [BS-1:0] mem_block;
    logic          mem_fifo_full = 1'b0;

    mem_refill_initiator #(
        .BLOCK_SIZE(BS), .ADDR_WIDTH(AW), .WB_DEPTH(WD), .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_block(resp_block),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_block(wb_block), .wb_ready(wb_ready),
        .mem_r_addr(mem_r_addr), .mem_block_ready(mem_block_ready), .mem_q(mem_q),
        .mem_we(mem_we), .mem_w_addr(mem_w_addr), .mem_block(mem_block),
        .mem_fifo_full(mem_fifo_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    function automatic void chk(string name, logic [BS-1:0] got, logic [BS-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, got, exp);
        end
    endfunction

    typedef struct { logic [BS-1:0] blk; int acc; int exact; } rexp_t;
    typedef struct { logic [AW-1:0] a; logic [BS-1:0] d; } wb_t;
    rexp_t rq[$];
    wb_t   wbq[$];

    // Memory model: explicit contents where set, otherwise an address-derived pattern.
    logic [BS-1:0] mem_arr [logic [AW-1:0]];
    function automatic logic [BS-1:0] mem_read(input logic [AW-1:0] a);
        logic [BS-1:0] r;
        if (mem_arr.exists(a)) r = mem_arr[a];
        else for (int i = 0; i < BS / 32; i++) r[32*i +: 32] = {a, 16'(i)} ^ 32'h5A3C_96E1;
        return r;
    endfunction

    // 0 = off, 1 = held high, 2 = random
    int ready_mode = 0;
    int full_mode  = 0;
    always @(posedge clk) begin
        #2;
        mem_block_ready = (ready_mode == 1) || (ready_mode == 2 && ($urandom % 3) == 0);
        mem_fifo_full   = (full_mode == 1) || (full_mode == 2 && ($urandom % 2) == 0);
        mem_q           = mem_read(mem_r_addr);
    end

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin : mon
        logic          push_now;
        logic          hz;
        logic          exp_we;
        logic [BS-1:0] fb;
        rexp_t         e;
        int            lat;
        if (rst) begin
            chk("rst_mem_we", mem_we, 0);
            chk("rst_req_ready", req_ready, 0);
            rq.delete();
            wbq.delete();
        end else begin
            push_now = wb_valid && wb_ready;
            if (resp_valid) begin
                checks++;
                if (rq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_resp actual=1 expected=0");
                end else begin
                    e = rq.pop_front();
                    chk("resp_block", resp_block, e.blk);
                    lat = cyc - e.acc;
                    if (e.exact != 0) chk("resp_latency", lat, e.exact);
                    else begin
                        checks++;
                        if (lat < SC + 2) begin
                            failures++;
                            $display("FAIL resp_min_latency actual=%0d expected>=%0d", lat, SC + 2);
                        end
                    end
                end
            end
            if (req_valid && req_ready) begin
                hz = 1'b0;
                fb = '0;
                foreach (wbq[i]) if (wbq[i].a == req_addr) begin hz = 1'b1; fb = wbq[i].d; end
                if (push_now && wb_addr == req_addr) begin hz = 1'b1; fb = wb_block; end
`ifdef WB_FORWARD_EN
                if (hz) e = '{fb, cyc, 1};
                else    e = '{mem_read(req_addr), cyc, (ready_mode == 1) ? SC + 2 : 0};
`else
                checks++;
                if (hz) begin
                    failures++;
                    $display("FAIL hazard_accept actual=%0h expected=stall", req_addr);
                end
                e = '{mem_read(req_addr), cyc, (ready_mode == 1) ? SC + 2 : 0};
`endif
                rq.push_back(e);
            end
            chk("wb_ready", wb_ready, wbq.size() < WD);
            exp_we = (wbq.size() > 0) && !mem_fifo_full;
            chk("mem_we", mem_we, exp_we);
            if (exp_we) begin
                chk("mem_w_addr", mem_w_addr, wbq[0].a);
                chk("mem_block", mem_block, wbq[0].d);
                void'(wbq.pop_front());
            end
            if (push_now) wbq.push_back('{wb_addr, wb_block});
        end
    end

    task automatic wait_accept();
        int n = 0;
        logic ok = 1'b0;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            n++;
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL accept_timeout actual=0 expected=1"); end
        @(posedge clk); #1 req_valid = 1'b0;
    endtask

    task automatic do_req(input logic [AW-1:0] a);
        @(posedge clk); #1 req_valid = 1'b1; req_addr = a;
        wait_accept();
    endtask

    task automatic wait_resp();
        int n = 0;
        while (rq.size() > 0 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (rq.size() > 0) begin failures++; $display("FAIL resp_timeout actual=0 expected=1"); end
    endtask

    task automatic wb_offer(input logic [AW-1:0] a, input logic [BS-1:0] d);
        int n = 0;
        logic ok = 1'b0;
        @(posedge clk); #1 wb_valid = 1'b1; wb_addr = a; wb_block = d;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (wb_ready) ok = 1'b1;
            n++;
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL wb_timeout actual=0 expected=1"); end
        @(posedge clk); #1 wb_valid = 1'b0;
    endtask

    function automatic logic [BS-1:0] rand_blk();
        logic [BS-1:0] r;
        for (int i = 0; i < BS / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin : main
        logic [BS-1:0] fada;
        logic [BS-1:0] cece;
        int nwe;
        fada = {16{16'hFADA}};
        cece = {16{16'hCECE}};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_resp_block", resp_block, 0);
        chk("reset_mem_r_addr", mem_r_addr, 0);
        chk("reset_wb_ready", wb_ready, 1);
        chk("reset_req_ready", req_ready, 1);

        // Slow memory: ready arrives 10 cycles after the request.
        mem_arr[16'h0003] = fada;
        do_req(16'h0003);
        repeat (10) @(posedge clk);
        #1 ready_mode = 1;
        wait_resp();
        ready_mode = 0;
        chk("slow_mem_r_addr", mem_r_addr, 16'h0003);
        repeat (3) @(negedge clk);
        chk("resp_block_hold", resp_block, fada);

        // Ready held high: exact minimum latency.
        ready_mode = 1;
        do_req(16'h0004);
        wait_resp();
        ready_mode = 0;

        // Fill the FIFO against a full memory, fifth offer must wait.
        full_mode = 1;
        for (int i = 0; i < 4; i++) wb_offer(16'h0010 + 16'(i), rand_blk());
        fork
            wb_offer(16'h0014, rand_blk());
        join_none
        repeat (3) @(negedge clk);
        chk("fifo_full_wb_ready", wb_ready, 0);
        @(posedge clk); #1 full_mode = 0;
        nwe = 0;
        repeat (8) begin @(negedge clk); if (mem_we) nwe++; end
        chk("drain_count", nwe, 5);
        chk("drain_empty", wbq.size(), 0);

        // Request to an address with a queued writeback.
        full_mode = 1;
        wb_offer(16'h0003, cece);
`ifdef WB_FORWARD_EN
        do_req(16'h0003);
        wait_resp();
        chk("fwd_resp_block", resp_block, cece);
        chk("fwd_mem_r_addr", mem_r_addr, 16'h0004);
        @(posedge clk); #1 full_mode = 0;
        repeat (3) @(negedge clk);
`else
        @(posedge clk); #1 req_valid = 1'b1; req_addr = 16'h0003;
        repeat (5) begin @(negedge clk); chk("hazard_stall", req_ready, 0); end
        @(posedge clk); #1 full_mode = 0; ready_mode = 1;
        wait_accept();
        wait_resp();
        ready_mode = 0;
        chk("post_drain_mem_r_addr", mem_r_addr, 16'h0003);
        chk("post_drain_resp_block", resp_block, fada);
`endif

        // Reset in WAIT_RDY with two queued writebacks.
        full_mode = 1;
        wb_offer(16'h0030, rand_blk());
        wb_offer(16'h0031, rand_blk());
        do_req(16'h0020);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; full_mode = 0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_mem_we", mem_we, 0);
            chk("post_rst_resp_valid", resp_valid, 0);
        end
        ready_mode = 1;
        do_req(16'h0021);
        wait_resp();
        chk("post_rst_mem_r_addr", mem_r_addr, 16'h0021);

        // Random concurrent traffic over a small address window to provoke hazards.
        full_mode = 2;
        ready_mode = 2;
        fork
            begin
                repeat (40) begin
                    repeat ($urandom % 3) @(posedge clk);
                    wb_offer(16'h0040 + 16'($urandom % 8), rand_blk());
                end
            end
            begin
                repeat (25) begin
                    do_req(16'h0040 + 16'($urandom % 8));
                    wait_resp();
                end
            end
        join
        ready_mode = 1;
        repeat (8) begin
            do_req(16'h0040 + 16'($urandom % 16));
            wait_resp();
        end
        full_mode = 0;
        ready_mode = 0;
        repeat (12) @(negedge clk);
        chk("final_wb_empty", wbq.size(), 0);
        chk("final_rq_empty", rq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
